// File: rtl/addsub_pipe_if.sv
// Operand/result stream bundle for addsub_pipe: producer-side handshake and
// operands, consumer-side handshake and flagged result.
interface addsub_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op1, op2, carry_in, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, op1, op2, carry_in, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES chunks, one
// register stage per chunk, with a valid/ready handshake on both sides.
module addsub_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic          clk,
    input logic          rst,
    addsub_pipe_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  r_src [STAGES];
    logic [WIDTH-1:0]  r_nxt [STAGES];
    logic [CHUNK:0]    sum;
    logic              msb_cin;

    always_comb begin
        v_src   = '0;
        c_src   = '0;
        c_nxt   = '0;
        a_src   = '{default: '0};
        b_src   = '{default: '0};
        r_src   = '{default: '0};
        r_nxt   = '{default: '0};
        sum     = '0;
        ld      = '0;

        // Subtraction is op1 + ~op2 + ~borrow, so every stage is a plain adder.
        a_src[0] = bus.op1;
        b_src[0] = bus.sub ? ~bus.op2 : bus.op2;
        r_src[0] = '0;
        c_src[0] = bus.sub ^ bus.carry_in;
        v_src[0] = bus.in_valid;
        for (int unsigned s = 1; s < STAGES; s++) begin
            a_src[s] = a_q[s-1];
            b_src[s] = b_q[s-1];
            r_src[s] = r_q[s-1];
            c_src[s] = c_q[s-1];
            v_src[s] = v_q[s-1];
        end

        for (int unsigned s = 0; s < STAGES; s++) begin
            sum = {1'b0, a_src[s][s*CHUNK +: CHUNK]}
                + {1'b0, b_src[s][s*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_src[s]};
            r_nxt[s]                  = r_src[s];
            r_nxt[s][s*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            c_nxt[s]                  = sum[CHUNK];
        end

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        msb_cin = r_nxt[LAST][WIDTH-1] ^ a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1];

        ld[LAST] = !v_q[LAST] || bus.out_ready;
        for (int unsigned s = LAST; s > 0; s--) begin
            ld[s-1] = !v_q[s-1] || ld[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                r_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    v_q[s] <= v_src[s];
                    // Payload only moves with a real beat so idle outputs hold.
                    if (v_src[s]) begin
                        a_q[s] <= a_src[s];
                        b_q[s] <= b_src[s];
                        r_q[s] <= r_nxt[s];
                        c_q[s] <= c_nxt[s];
                    end
                end
            end
            if (ld[LAST] && v_src[LAST]) begin
                ovf_q  <= msb_cin ^ c_nxt[LAST];
                zero_q <= (r_nxt[LAST] == '0);
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.result    = r_q[LAST];
    assign bus.carry_out = c_q[LAST];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Randomised and directed bench for addsub_pipe (WIDTH=64, STAGES=4) with an
// arithmetic reference model and an in-order expectation queue.
module tb_addsub_pipe;
    localparam int W  = 64;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(W)) bus ();
    addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t held;
    bit   hold = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: wide unsigned arithmetic for result/carry, wide signed for overflow.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s);
        exp_t e;
        logic [64:0] full;
        logic signed [65:0] sa, sb, sc, t;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        sc = {65'd0, ci};
        if (s) begin
            e.r = a - b - 64'(ci);
            e.c = ({1'b0, a} >= ({1'b0, b} + 65'(ci)));
            t   = sa - sb - sc;
        end else begin
            full = {1'b0, a} + {1'b0, b} + 65'(ci);
            e.r  = full[63:0];
            e.c  = full[64];
            t    = sa + sb + sc;
        end
        e.v = (t[65:63] != 3'b000) && (t[65:63] != 3'b111);
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_result", bus.result, held.r);
                chk("hold_flags", 64'({bus.carry_out, bus.overflow, bus.zero}),
                    64'({held.c, held.v, held.z}));
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=out_valid required=no_beat result=%h", bus.result);
                end else begin
                    mon_e = q[0];
                    chk("model_result", bus.result, mon_e.r);
                    chk("model_flags", 64'({bus.carry_out, bus.overflow, bus.zero}),
                        64'({mon_e.c, mon_e.v, mon_e.z}));
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            hold   = bus.out_valid && !bus.out_ready;
            held.r = bus.result;
            held.c = bus.carry_out;
            held.v = bus.overflow;
            held.z = bus.zero;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.op1, bus.op2, bus.carry_in, bus.sub));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        bus.op1 = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       bus.op2 = ~bus.op1;
            1:       bus.op2 = '1;
            2:       bus.op2 = bus.op1;
            default: bus.op2 = {$urandom, $urandom};
        endcase
        bus.carry_in = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic ci, input logic s, input logic [63:0] er,
                            input logic ec, input logic ev, input logic ez);
        int lat;
        step();
        bus.op1 = a; bus.op2 = b; bus.carry_in = ci; bus.sub = s;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            step();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(ST));
        chk({name, "_result"}, bus.result, er);
        chk({name, "_flags"}, 64'({bus.carry_out, bus.overflow, bus.zero}), 64'({ec, ev, ez}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, outs, sent, cyc;
        bus.in_valid = 1'b0; bus.op1 = '0; bus.op2 = '0;
        bus.carry_in = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_flags", 64'({bus.carry_out, bus.overflow, bus.zero}), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        directed("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        directed("chunk_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        directed("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_cin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
        directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Capacity under a stalled consumer, then full-rate streaming.
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        chk("capacity", 64'(acc), 64'(ST));
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.out_ready = 1'b1;
        acc = 0; outs = 0;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            @(negedge clk);
            if (bus.in_ready) acc++;
            if (bus.out_valid) outs++;
            step();
        end
        chk("stream_accepts", 64'(acc), 64'd20);
        chk("stream_outputs", 64'(outs), 64'd20);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (q.size() != 0 && cyc < 40) begin step(); cyc++; end
        chk("drain1_empty", 64'(q.size()), 64'd0);

        // Random valid/ready toggling on both sides.
        sent = 0; cyc = 0;
        while (sent < 32 && cyc < 2000) begin
            rand_ops();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            step();
            cyc++;
        end
        chk("random_sent", 64'(sent), 64'd32);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 40) begin step(); cyc++; end
        chk("drain2_empty", 64'(q.size()), 64'd0);

        // Reset with three beats in flight.
        acc = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        chk("midflight_accepts", 64'(acc), 64'd3);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        outs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (bus.out_valid) outs++;
        end
        chk("post_rst_no_stale", 64'(outs), 64'd0);
        directed("post_rst_beat", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
